// File: rtl/cl_axi_wr_burst_seq_if.sv
// AXI write-half bundle (AW/W/B) for the 512-bit CL bus.
// The master modport is the sequencer side; the slave modport is the DDR side.
interface cl_axi_wr_burst_seq_if;
    logic [15:0]  awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [15:0]  wid;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cl_axi_wr_burst_seq.sv
// Write-burst sequencer: back-to-back INCR bursts of a seeded pattern toward DDR.
// Optional watchdog: define CL_WR_SEQ_TIMEOUT_EN to enable it.
module cl_axi_wr_burst_seq #(
    parameter logic [15:0] AXI_ID      = 16'h0,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [63:0]                  cfg_base_addr,
    input  logic [15:0]                  cfg_num_bursts,
    input  logic [7:0]                   cfg_len,
    input  logic [31:0]                  cfg_seed,
    cl_axi_wr_burst_seq_if.master        axi,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  bursts_done,
    output logic                         timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [63:0] cur_addr;
    logic [15:0] num;
    logic [7:0]  len;
    logic [31:0] pat;
    logic [7:0]  beat;

    logic start_ok;
    logic cfg_bad;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic last_b;
    logic wd_fire;

    assign start_ok = cfg_start && (state == S_IDLE);
    assign cfg_bad  = (cfg_base_addr[5:0] != 6'd0) || (cfg_len > 8'd63);
    assign aw_hs    = axi.awvalid && axi.awready;
    assign w_hs     = axi.wvalid && axi.wready;
    assign b_hs     = axi.bvalid && axi.bready;
    assign last_b   = (bursts_done + 16'd1) == num;

`ifdef CL_WR_SEQ_TIMEOUT_EN
    logic [31:0] wd;
    logic        active;
    logic        hs_act;

    assign active = (state == S_AW) || (state == S_W) || (state == S_B);
    assign hs_act = ((state == S_AW) && aw_hs) ||
                    ((state == S_W) && w_hs) ||
                    ((state == S_B) && b_hs);
    assign wd_fire = active && !hs_act && (wd == 32'(TIMEOUT_CYC - 1));

    // Watchdog: cycles spent on the active channel since its last handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (!active || hs_act || wd_fire) begin
            wd <= '0;
        end else begin
            wd <= wd + 32'd1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic; a bad or empty config skips the bus entirely.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    if (cfg_bad || (cfg_num_bursts == 16'd0)) begin
                        nxt = S_DONE;
                    end else begin
                        nxt = S_AW;
                    end
                end
            end
            S_AW: begin
                if (wd_fire) begin
                    nxt = S_DONE;
                end else if (aw_hs) begin
                    nxt = S_W;
                end
            end
            S_W: begin
                if (wd_fire) begin
                    nxt = S_DONE;
                end else if (w_hs && (beat == len)) begin
                    nxt = S_B;
                end
            end
            S_B: begin
                if (wd_fire) begin
                    nxt = S_DONE;
                end else if (b_hs) begin
                    nxt = last_b ? S_DONE : S_AW;
                end
            end
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Bus outputs decoded from the registered state; payloads are 0 off-channel.
    always_comb begin
        axi.awid    = AXI_ID;
        axi.wid     = AXI_ID;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awsize  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        unique case (state)
            S_AW: begin
                axi.awvalid = 1'b1;
                axi.awaddr  = cur_addr;
                axi.awlen   = len;
                axi.awsize  = 3'b110;
            end
            S_W: begin
                axi.wvalid = 1'b1;
                axi.wdata  = {16{pat}};
                axi.wstrb  = '1;
                axi.wlast  = (beat == len);
            end
            S_B: axi.bready = 1'b1;
            default: ;
        endcase
    end

    // Config latch, pattern/beat/address progress and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr    <= '0;
            num         <= '0;
            len         <= '0;
            pat         <= '0;
            beat        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bursts_done <= '0;
            timeout     <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                busy <= 1'b0;
            end
            if (start_ok) begin
                cur_addr    <= cfg_base_addr;
                num         <= cfg_num_bursts;
                len         <= cfg_len;
                pat         <= cfg_seed;
                beat        <= '0;
                busy        <= 1'b1;
                err         <= cfg_bad;
                bursts_done <= '0;
                timeout     <= 1'b0;
            end
            if (w_hs) begin
                pat  <= pat + 32'd1;
                beat <= (beat == len) ? 8'd0 : beat + 8'd1;
            end
            if (b_hs) begin
                bursts_done <= bursts_done + 16'd1;
                cur_addr    <= cur_addr + (({56'd0, len} + 64'd1) << 6);
                if (axi.bresp != 2'b00) begin
                    err <= 1'b1;
                end
            end
            if (wd_fire) begin
                timeout <= 1'b1;
                err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cl_axi_wr_burst_seq.sv
// Scoreboard bench for cl_axi_wr_burst_seq: random DDR slave plus burst model.
// Watchdog section follows CL_WR_SEQ_TIMEOUT_EN.
module tb_cl_axi_wr_burst_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [63:0] cfg_base_addr = '0;
    logic [15:0] cfg_num_bursts = '0;
    logic [7:0]  cfg_len = '0;
    logic [31:0] cfg_seed = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic        timeout;
    logic [15:0] bursts_done;

    always #5 clk = ~clk;

    cl_axi_wr_burst_seq_if axi ();

    cl_axi_wr_burst_seq #(
        .AXI_ID      (16'h0),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_num_bursts (cfg_num_bursts),
        .cfg_len        (cfg_len),
        .cfg_seed       (cfg_seed),
        .axi            (axi),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .bursts_done    (bursts_done),
        .timeout        (timeout)
    );

    int vecs = 0;
    int miss = 0;

    logic [71:0] aw_q[$];
    logic [32:0] w_q[$];
    logic [17:0] d_q[$];

    int mode = 0;
    int b_pend = 0;
    int b_idx = 0;
    int err_burst = -1;
    int aw_wait = 0;
    bit chk_stable = 1'b1;
    bit aw_stall = 1'b0;
    bit w_stall = 1'b0;
    bit b_last = 1'b0;
    logic [63:0]  aw_prev;
    logic [511:0] w_prev;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // DDR slave model and scoreboard monitor.
    always @(negedge clk) begin : mon
        logic aw_hs;
        logic w_hs;
        logic b_hs;
        logic [71:0]  ea;
        logic [32:0]  ew;
        logic [17:0]  ed;
        logic [511:0] ewd;
        if (rst) begin
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            axi.bvalid  = 1'b0;
            axi.bresp   = 2'b00;
            axi.bid     = 16'h0;
            b_pend   = 0;
            aw_wait  = 0;
            aw_stall = 1'b0;
            w_stall  = 1'b0;
            b_last   = 1'b0;
            aw_q.delete();
            w_q.delete();
            d_q.delete();
        end else begin
            if (b_last) axi.bvalid = 1'b0;
            if (chk_stable && aw_stall) begin
                chk("aw_hold", axi.awvalid, 1);
                chk("aw_stable", axi.awaddr, aw_prev);
            end
            if (chk_stable && w_stall) begin
                chk("w_hold", axi.wvalid, 1);
                chk("w_stable", axi.wdata, w_prev);
            end
            case (mode)
                0: begin
                    axi.awready = 1'b1;
                    axi.wready  = 1'b1;
                end
                1: begin
                    axi.awready = $urandom_range(3, 0) != 0;
                    axi.wready  = $urandom_range(3, 0) != 0;
                end
                2: begin
                    axi.awready = axi.awvalid && (aw_wait >= 5);
                    axi.wready  = ~axi.wready;
                end
                default: begin
                    axi.awready = 1'b0;
                    axi.wready  = 1'b1;
                end
            endcase
            if (!axi.bvalid)
                axi.bvalid = (b_pend > 0) &&
                             (mode != 1 || $urandom_range(1, 0) == 1);
            axi.bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;

            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            b_hs  = axi.bvalid && axi.bready;
            aw_stall = axi.awvalid && !axi.awready;
            w_stall  = axi.wvalid && !axi.wready;
            aw_prev  = axi.awaddr;
            w_prev   = axi.wdata;
            if (aw_stall) aw_wait++;
            if (aw_hs) aw_wait = 0;

            if (axi.awvalid && aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            if (axi.wvalid && w_q.size() == 0) chk("w_unexpected", 1, 0);
            if (aw_hs && aw_q.size() > 0) begin
                ea = aw_q.pop_front();
                chk("awaddr", axi.awaddr, ea[63:0]);
                chk("awlen", axi.awlen, ea[71:64]);
                chk("awsize", axi.awsize, 3'b110);
            end
            if (w_hs && w_q.size() > 0) begin
                ew  = w_q.pop_front();
                ewd = {16{ew[31:0]}};
                chk("wdata", axi.wdata, ewd);
                chk("wlast", axi.wlast, ew[32]);
                chk("wstrb", axi.wstrb, {64{1'b1}});
            end
            if (w_hs && axi.wlast) b_pend++;
            b_last = b_hs;
            if (b_hs) begin
                b_pend--;
                b_idx++;
            end
            if (done) begin
                if (d_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    ed = d_q.pop_front();
                    chk("done_timeout", timeout, ed[17]);
                    chk("done_err", err, ed[16]);
                    chk("done_bursts", bursts_done, ed[15:0]);
                    chk("done_busy", busy, 0);
                end
            end
        end
    end

    // Expected bursts from the address/pattern rules, queued in order.
    task automatic push_model(input logic [63:0] base, input logic [15:0] num,
                              input logic [7:0] len, input logic [31:0] seed,
                              input int ebur);
        bit bad;
        bit anyerr;
        logic [63:0] step;
        logic [31:0] word;
        bad    = (base[5:0] != 6'd0) || (len > 8'd63);
        anyerr = (ebur >= 0) && (ebur < int'(num));
        step   = (64'(len) + 64'd1) * 64'd64;
        if (!bad) begin
            for (int b = 0; b < int'(num); b++) begin
                aw_q.push_back({len, base + 64'(b) * step});
                for (int k = 0; k <= int'(len); k++) begin
                    word = seed + 32'(b) * (32'(len) + 32'd1) + 32'(k);
                    w_q.push_back({k == int'(len), word});
                end
            end
        end
        d_q.push_back({1'b0, bad || anyerr, bad ? 16'd0 : num});
        err_burst = ebur;
        b_idx = 0;
    endtask

    task automatic start_seq(input logic [63:0] base, input logic [15:0] num,
                             input logic [7:0] len, input logic [31:0] seed);
        @(negedge clk);
        cfg_base_addr  = base;
        cfg_num_bursts = num;
        cfg_len        = len;
        cfg_seed       = seed;
        cfg_start      = 1'b1;
    endtask

    task automatic wait_done(input bit poke, output int lat);
        bit poked;
        poked = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            cfg_start = 1'b0;
            if (done) break;
            if (lat >= 5000) begin
                chk("done_wait", 0, 1);
                break;
            end
            if (poke && !poked && axi.wvalid) begin
                poked = 1'b1;
                cfg_start      = 1'b1;
                cfg_base_addr  = {$urandom, $urandom};
                cfg_num_bursts = 16'($urandom);
                cfg_len        = 8'($urandom);
                cfg_seed       = $urandom;
            end
        end
    endtask

    task automatic run_seq(input logic [63:0] base, input logic [15:0] num,
                           input logic [7:0] len, input logic [31:0] seed,
                           input int ebur, input bit poke, output int lat);
        push_model(base, num, len, seed, ebur);
        start_seq(base, num, len, seed);
        wait_done(poke, lat);
    endtask

    initial begin
        int lat;
        int n;
        logic [63:0] rb;
        logic [15:0] rn;
        logic [7:0]  rl;
        int re;

        repeat (3) @(negedge clk);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_wdata", axi.wdata, 0);
        chk("rst_status", {busy, done, err, timeout, bursts_done}, 0);
        rst = 1'b0;

        mode = 0;
        run_seq(64'h1000, 16'd2, 8'd3, 32'h10, -1, 1'b0, lat);
        chk("basic_bursts", bursts_done, 2);
        chk("basic_err", err, 0);

        mode = 2;
        run_seq(64'h2000, 16'd2, 8'd3, 32'hA0, -1, 1'b0, lat);

        mode = 1;
        run_seq(64'h40000, 16'd3, 8'd3, 32'h55, 1, 1'b0, lat);
        chk("bresp_err_hold", err, 1);

        run_seq(64'h1004, 16'd2, 8'd3, 32'h1, -1, 1'b0, lat);
        run_seq(64'h3000, 16'd2, 8'd64, 32'h2, -1, 1'b0, lat);
        run_seq(64'h3000, 16'd0, 8'd3, 32'h3, -1, 1'b0, lat);
        chk("num0_latency", lat, 2);

        run_seq(64'h5000, 16'd3, 8'd7, 32'hBEEF, -1, 1'b1, lat);

        push_model(64'h6000, 16'd4, 8'd7, 32'h600, -1);
        start_seq(64'h6000, 16'd4, 8'd7, 32'h600);
        n = 0;
        do begin
            @(negedge clk);
            cfg_start = 1'b0;
            n++;
        end while (!axi.wvalid && n < 200);
        chk("midw_reached", axi.wvalid, 1);
        rst = 1'b1;
        #1;
        chk("arst_valids", {axi.awvalid, axi.wvalid, axi.bready}, 0);
        chk("arst_wdata", axi.wdata, 0);
        chk("arst_status", {busy, done, err, timeout, bursts_done}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode = 1;
        run_seq(64'h8000, 16'd2, 8'd2, 32'h77, 0, 1'b0, lat);

        for (int i = 0; i < 12; i++) begin
            rb = {$urandom, $urandom};
            rb[5:0] = 6'd0;
            if (i == 5) rb[2] = 1'b1;
            rn = 16'($urandom_range(5, 1));
            rl = 8'($urandom_range(15, 0));
            if (i == 7) rl = 8'd63;
            re = $urandom_range(6, 0) - 1;
            run_seq(rb, rn, rl, $urandom, re, i[0], lat);
        end

`ifdef CL_WR_SEQ_TIMEOUT_EN
        mode = 3;
        chk_stable = 1'b0;
        aw_q.push_back({8'd3, 64'h7000});
        d_q.push_back({1'b1, 1'b1, 16'd0});
        start_seq(64'h7000, 16'd1, 8'd3, 32'h9);
        n = 0;
        do begin
            @(negedge clk);
            cfg_start = 1'b0;
            n++;
        end while (!axi.awvalid && n < 50);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("wd_latency", lat, 17);
        chk("wd_awvalid", axi.awvalid, 0);
        chk("wd_flag", timeout, 1);
        aw_q.delete();
        chk_stable = 1'b1;
        mode = 0;
`else
        mode = 3;
        push_model(64'h7000, 16'd1, 8'd3, 32'h9, -1);
        start_seq(64'h7000, 16'd1, 8'd3, 32'h9);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (done) n++;
        end
        chk("hang_awvalid", axi.awvalid, 1);
        chk("hang_busy", busy, 1);
        chk("hang_nodone", n, 0);
        mode = 0;
        wait_done(1'b0, lat);
        chk("hang_timeout", timeout, 0);
`endif

        repeat (3) @(negedge clk);
        chk("queues_empty", aw_q.size() + w_q.size() + d_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
